// File: rtl/led_pkg.sv
// Shared types, opcode constants and lookup helpers for the LED strip engine.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [3:0] OP_OFF   = 4'b0000;
  localparam logic [3:0] OP_SOLID = 4'b0001;
  localparam logic [3:0] OP_CHASE = 4'b0010;
  localparam logic [3:0] OP_BLINK = 4'b0011;
  localparam logic [3:0] OP_BR_UP = 4'b0100;
  localparam logic [3:0] OP_BR_DN = 4'b0101;
  localparam logic [3:0] OP_PAUSE = 4'b0110;
  localparam logic [3:0] OP_DIR   = 4'b0111;
  localparam logic       OP_COLOR = 1'b1;

  // Perceptual gains per brightness level, 6 bits each, level 0 in the low slot.
  localparam logic [47:0] GAMMA_TBL = {6'd32, 6'd21, 6'd14, 6'd9, 6'd6, 6'd4, 6'd2, 6'd1};

  function automatic logic [2:0] color_lut(input logic [2:0] code);
    logic [2:0] mask;
    case (code)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b100;
      3'd2:    mask = 3'b010;
      3'd3:    mask = 3'b001;
      3'd4:    mask = 3'b110;
      3'd5:    mask = 3'b011;
      3'd6:    mask = 3'b101;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/led_step_timer.sv
// Animation step divider: counts 0..TICK_DIV-1, pulses on the last count, holds while paused.
module led_step_timer
  import led_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold_i,
  input  logic clr_i,
  output logic step_pulse_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_pulse_o = !hold_i && (cnt_q == CNT_LAST);

  always_comb begin
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (hold_i) begin
      cnt_d = cnt_q;
    end else if (step_pulse_o) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_strip_engine.sv
// LED strip pattern engine (OFF/SOLID/CHASE/BLINK) with registered RGB strip output.
// Define GAMMA_EN to replace linear brightness scaling with a perceptual gain table.
module led_strip_engine
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int COLOR_W  = 8,
  parameter int TICK_DIV = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [3:0]                      op_code,
  input  logic                            op_valid,
  output logic [NUM_LEDS*3*COLOR_W-1:0]   strip,
  output logic [2:0]                      brightness,
  output logic [1:0]                      mode,
  output logic                            step_pulse
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
`ifdef GAMMA_EN
  localparam int PROD_W = COLOR_W + 6;
`else
  localparam int PROD_W = COLOR_W + 4;
`endif

  mode_e                      mode_q, mode_d;
  logic [2:0]                 color_q, color_d;
  logic [2:0]                 bright_q, bright_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic                       dir_q, dir_d;
  logic                       paused_q, paused_d;
  logic                       blink_q, blink_d;
  logic [NUM_LEDS*PIX_W-1:0]  strip_q, strip_d;
  logic                       mode_set_s;
  logic                       step_s;
  logic [2:0]                 rgb_mask_s;
  logic [PROD_W-1:0]          prod_s;
  logic [COLOR_W-1:0]         chan_s;
  logic [PIX_W-1:0]           pix_s;

  assign mode_set_s = op_valid && (op_code[3:2] == 2'b00);

  led_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_i       (paused_q),
    .clr_i        (mode_set_s),
    .step_pulse_o (step_s)
  );

  // A mode write restarts the animation; otherwise a step advances it using the updated direction.
  always_comb begin
    mode_d   = mode_q;
    color_d  = color_q;
    bright_d = bright_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    paused_d = paused_q;
    blink_d  = blink_q;
    if (op_valid) begin
      if (op_code[3] == OP_COLOR) begin
        color_d = op_code[2:0];
      end else begin
        case (op_code)
          OP_OFF, OP_SOLID, OP_CHASE, OP_BLINK: begin
            mode_d  = mode_e'(op_code[1:0]);
            blink_d = 1'b1;
            pos_d   = dir_q ? POS_LAST : {POS_W{1'b0}};
          end
          OP_BR_UP: bright_d = (bright_q == 3'd7) ? 3'd7 : bright_q + 3'd1;
          OP_BR_DN: bright_d = (bright_q == 3'd0) ? 3'd0 : bright_q - 3'd1;
          OP_PAUSE: paused_d = !paused_q;
          OP_DIR:   dir_d    = !dir_q;
          default:  paused_d = paused_q;
        endcase
      end
    end else begin
      color_d = color_q;
    end
    if (step_s && !mode_set_s) begin
      case (mode_q)
        MODE_CHASE: begin
          if (dir_d) begin
            pos_d = (pos_q == {POS_W{1'b0}}) ? POS_LAST : pos_q - POS_W'(1);
          end else begin
            pos_d = (pos_q == POS_LAST) ? {POS_W{1'b0}} : pos_q + POS_W'(1);
          end
        end
        MODE_BLINK: blink_d = !blink_q;
        default:    blink_d = blink_q;
      endcase
    end else begin
      blink_d = blink_d;
    end
  end

  always_comb begin
    rgb_mask_s = color_lut(color_q);
`ifdef GAMMA_EN
    prod_s = PROD_W'({COLOR_W{1'b1}}) * PROD_W'(GAMMA_TBL[int'(bright_q)*6 +: 6]);
    chan_s = COLOR_W'(prod_s >> 5);
`else
    prod_s = PROD_W'({COLOR_W{1'b1}}) * (PROD_W'(bright_q) + PROD_W'(1));
    chan_s = COLOR_W'(prod_s >> 3);
`endif
    pix_s = {rgb_mask_s[2] ? chan_s : {COLOR_W{1'b0}},
             rgb_mask_s[1] ? chan_s : {COLOR_W{1'b0}},
             rgb_mask_s[0] ? chan_s : {COLOR_W{1'b0}}};
  end

  always_comb begin
    strip_d = {(NUM_LEDS*PIX_W){1'b0}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode_q)
        MODE_SOLID: strip_d[i*PIX_W +: PIX_W] = pix_s;
        MODE_CHASE: strip_d[i*PIX_W +: PIX_W] = (pos_q == POS_W'(i)) ? pix_s : {PIX_W{1'b0}};
        MODE_BLINK: strip_d[i*PIX_W +: PIX_W] = blink_q ? pix_s : {PIX_W{1'b0}};
        default:    strip_d[i*PIX_W +: PIX_W] = {PIX_W{1'b0}};
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= MODE_OFF;
      color_q  <= 3'd7;
      bright_q <= 3'd7;
      pos_q    <= {POS_W{1'b0}};
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      blink_q  <= 1'b1;
      strip_q  <= {(NUM_LEDS*PIX_W){1'b0}};
    end else begin
      mode_q   <= mode_d;
      color_q  <= color_d;
      bright_q <= bright_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      blink_q  <= blink_d;
      strip_q  <= strip_d;
    end
  end

  assign strip      = strip_q;
  assign brightness = bright_q;
  assign mode       = mode_q;
  assign step_pulse = step_s;

endmodule
